// File: rtl/dac_i2c_writer.sv
// rtl/dac_i2c_writer.sv - MCP4725 Fast Write sequencer driving an open-drain I2C pair
module dac_i2c_writer #(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'h60
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        dac_adjustment,
  input  logic [11:0] new_vol,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  localparam int              DIVW     = $clog2(CLK_DIV);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [DIVW-1:0] r_div;
  logic [1:0]      r_quarter;
  logic [2:0]      r_bit;
  logic [1:0]      r_byte;
  logic [11:0]     r_vol_q;
  logic [11:0]     r_pend_q;
  logic            r_pending;
  logic            r_req_d;
  logic            r_ack_err;
  logic            r_nack;

  logic            w_req;
  logic            w_q_end;
  logic            w_frame_end;
  logic [7:0]      w_byte_val;
  logic            w_bit_val;
  logic            w_scl_oe;
  logic            w_sda_oe;

  // A request is a 1->0 transition; holding the line low yields a single request.
  assign w_req       = r_req_d & ~dac_adjustment;
  assign w_q_end     = (r_state != S_IDLE) && (r_div == DIV_LAST);
  assign w_frame_end = w_q_end && (r_quarter == 2'd3);

  // Select the byte currently on the wire and the bit within it.
  always_comb begin
    w_byte_val = 8'h00;
    case (r_byte)
      2'd0:    w_byte_val = {DEV_ADDR, 1'b0};
      2'd1:    w_byte_val = {4'b0000, r_vol_q[11:8]};
      default: w_byte_val = r_vol_q[7:0];
    endcase
    w_bit_val = w_byte_val[r_bit];
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and bus drive per state and quarter.
  always_comb begin
    w_next_state = r_state;
    w_scl_oe     = 1'b0;
    w_sda_oe     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_next_state = S_START;
      end
      S_START: begin
        // SDA falls while SCL is high, then SCL is pulled low.
        w_sda_oe = (r_quarter != 2'd0);
        w_scl_oe = r_quarter[1];
        if (w_frame_end) w_next_state = S_BIT;
      end
      S_BIT: begin
        w_scl_oe = (r_quarter == 2'd0) || (r_quarter == 2'd3);
        w_sda_oe = ~w_bit_val;
        if (w_frame_end && (r_bit == 3'd0)) w_next_state = S_ACK;
      end
      S_ACK: begin
        w_scl_oe = (r_quarter == 2'd0) || (r_quarter == 2'd3);
        if (w_frame_end) begin
          if (r_nack || (r_byte == 2'd2)) w_next_state = S_STOP;
          else                            w_next_state = S_BIT;
        end
      end
      S_STOP: begin
        // SCL released first, then SDA rises while SCL is high.
        w_scl_oe = (r_quarter == 2'd0);
        w_sda_oe = (r_quarter <= 2'd1);
        if (w_frame_end) begin
          if (r_pending || w_req) w_next_state = S_START;
          else                    w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Divider, bit/byte indices, code latches, pending slot and ACK status.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_req_d   <= 1'b1;
      r_div     <= '0;
      r_quarter <= 2'd0;
      r_bit     <= 3'd7;
      r_byte    <= 2'd0;
      r_vol_q   <= 12'h000;
      r_pend_q  <= 12'h000;
      r_pending <= 1'b0;
      r_ack_err <= 1'b0;
      r_nack    <= 1'b0;
    end else begin
      r_req_d <= dac_adjustment;
      if (r_state == S_IDLE) begin
        r_div     <= '0;
        r_quarter <= 2'd0;
        if (w_req) begin
          r_vol_q   <= new_vol;
          r_ack_err <= 1'b0;
          r_nack    <= 1'b0;
          r_bit     <= 3'd7;
          r_byte    <= 2'd0;
        end
      end else begin
        if (w_q_end) begin
          r_div     <= '0;
          r_quarter <= r_quarter + 2'd1;
        end else begin
          r_div <= r_div + 1'b1;
        end

        // Newest request wins; older pending codes are overwritten.
        if (w_req) begin
          r_pending <= 1'b1;
          r_pend_q  <= new_vol;
        end

        // Bit index wraps 0 -> 7, ready for the next byte.
        if ((r_state == S_BIT) && w_frame_end) begin
          r_bit <= r_bit - 3'd1;
        end

        if ((r_state == S_ACK) && w_q_end && (r_quarter == 2'd2)) begin
          r_nack <= sda_in;
          if (sda_in) r_ack_err <= 1'b1;
        end

        if ((r_state == S_ACK) && w_frame_end && !r_nack) begin
          r_byte <= r_byte + 2'd1;
        end

        // End of frame: launch the follow-up write if one is waiting.
        if ((r_state == S_STOP) && w_frame_end) begin
          r_pending <= 1'b0;
          r_bit     <= 3'd7;
          r_byte    <= 2'd0;
          r_nack    <= 1'b0;
          if (w_req || r_pending) begin
            r_ack_err <= 1'b0;
            r_vol_q   <= w_req ? new_vol : r_pend_q;
          end
        end
      end
    end
  end

  assign scl_oe  = w_scl_oe;
  assign sda_oe  = w_sda_oe;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_STOP) && w_frame_end;
  assign ack_err = r_ack_err;

endmodule

// File: doc/dac_i2c_writer.md
# dac_i2c_writer

Downstream stage of the voltage feedback loop: takes each new 12-bit DAC code produced by the pulse adjuster and writes it to an MCP4725-class I2C DAC using a single Fast Write transaction. The adjuster signals a new code by pulling `dac_adjustment` low. This block detects that falling edge, latches `new_vol`, and sequences START, three bytes with ACKs, and STOP on an open-drain SCL/SDA pair. Requests that arrive while a write is in progress are coalesced, so the newest code is always written last.

## Interface
- `CLK_DIV`, 125: clk_in cycles per SCL quarter-period (125 at 50 MHz gives 100 kHz). Legal range is 2 or more.
- `DEV_ADDR`, 7'h60: 7-bit I2C device address.
- `clk_in`  in  1  system clock. Everything is clocked on the rising edge.
- `reset_in`  in  1  **synchronous, active-high reset**.
- `dac_adjustment`  in  1  request from the adjuster. A 1→0 transition requests a write.
- `new_vol`  in  12  DAC code. Sampled in the same cycle the falling edge is detected.
- `sda_in`  in  1  synchronised SDA pin level.
- `scl_oe`  out  1  1 = drive SCL low, 0 = release.
- `sda_oe`  out  1  1 = drive SDA low, 0 = release.
- `busy`  out  1  a transaction is in progress.
- `done`  out  1  one-cycle pulse when a transaction ends (normally or aborted).
- `ack_err`  out  1  sticky NACK flag. Cleared when the next transaction starts.

## Operation
- **Edge detect**
  - Register `dac_adjustment` into `req_d`.
  - A request is `req_d & ~dac_adjustment`.
  - Holding the input low produces only one request.
- **Request latching**
  - While idle: a request latches `new_vol` into `vol_q` and enters START.
  - While busy: a request sets `pending` and latches `new_vol` into `pend_q`. Later requests overwrite `pend_q`; only one pending write is kept.
- **Frame format**, MSB first, each byte followed by an ACK slot:
  - Byte 0: {DEV_ADDR, 1'b0}.
  - Byte 1: {2'b00 fast-write, 2'b00 normal power, vol_q[11:8]}.
  - Byte 2: vol_q[7:0].
- **States:** IDLE, START, BIT, ACK, STOP. Every state except IDLE lasts exactly 4 quarters (q0..q3).
  - **START**
    - q0: both lines released.
    - q1: SDA low.
    - q2, q3: SCL low and SDA low.
    - Then BIT, with bit index 7 and byte 0.
  - **BIT**
    - q0: SCL low; SDA = ~bit, i.e. sda_oe = 1 for a 0 bit.
    - q1, q2: SCL released.
    - q3: SCL low.
    - Decrement the bit index. After bit 0, go to ACK.
  - **ACK**
    - SDA released in all quarters; SCL follows the same pattern as BIT.
    - At the end of q2, sample `sda_in`.
    - Sampled 0: go to the next byte, or to STOP after byte 2.
    - Sampled 1: set `ack_err` and go to STOP. Remaining bytes are skipped.
  - **STOP**
    - q0: SCL low, SDA low.
    - q1: SCL released.
    - q2: SDA released.
    - q3: idle hold.
    - At the end of q3: pulse `done`.
      - If `pending`: copy `pend_q` to `vol_q`, clear `pending`, clear `ack_err`, enter START next cycle. `busy` stays 1.
      - Otherwise: go to IDLE with `busy` = 0.
- **Divider:** reloads at 0 on entry to START, so each quarter is exactly CLK_DIV cycles.
- **Simultaneous events:** a request in the same cycle as the STOP-q3 end is captured into `pend_q`, and it takes priority as the follow-up write.

## Timing
- **Reset values:** scl_oe = 0, sda_oe = 0, busy = 0, done = 0, ack_err = 0, pending = 0, req_d = 1, state = IDLE.
- **Request latency:** falling edge sampled at cycle N (input low at N, `req_d` = 1). At N+1: `busy` = 1, `vol_q` valid, START q0 begins.
- **Full transaction length:** (4 + 27×4 + 4) = 116 quarters = 116×CLK_DIV cycles. `done` is high in the last cycle; `busy` falls in the following cycle.
- **Transaction aborted at the address NACK:** 4 + 9×4 + 4 = 44 quarters.
- **SDA changes only while SCL is low,** except for the START and STOP conditions.
- **Reset mid-transaction:** on the next edge, both oe outputs are 0, busy = 0, pending is cleared, and no `done` pulse is emitted. Any partial frame is abandoned.

## Test plan
- **Reset:** assert reset_in for 3 cycles → all outputs 0; no bus activity for 1000 cycles with dac_adjustment = 1.
- **Single write** (CLK_DIV = 4): dac_adjustment 1→0 with new_vol = 12'h2BC, slave ACKs every byte →
  - decoded bytes are 0xC0, 0x02, 0xBC;
  - `done` arrives 464 cycles after `busy` rises;
  - ack_err = 0.
- **Address NACK:** slave leaves SDA high at the first ACK → ack_err = 1, STOP follows, `done` arrives 176 cycles after start, and no data bytes appear on the bus.
- **Coalescing:** during a write of 0x2BC, issue requests with 0x2BD and then 0x2BE → exactly one follow-up transaction, carrying 0x2BE. `busy` stays high continuously across both transactions.
- **Level hold:** keep dac_adjustment low for 2000 cycles after a single edge → exactly one transaction.
- **Mid-frame reset:** assert reset_in during byte 1 → scl_oe = sda_oe = 0 and busy = 0 on the next cycle; no `done` pulse; a new request afterwards writes a complete, correct frame.
